multiplier_control: RTL



---
 rtl/mult_pkg.sv | 19 +
 rtl/ripple_adder.sv | 24 ++
 rtl/multiplier_control.sv | 101 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared widths, state encoding and counter type for the 8-bit signed shift-add multiplier.
package mult_pkg;

    localparam int MULT_W = 8;
    localparam int N_ITER = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        HOLD
    } state_t;

    typedef logic [2:0] cnt_t;

    localparam cnt_t LAST_ITER = cnt_t'(N_ITER - 1);

endpackage

// File: rtl/ripple_adder.sv
// 9-bit ripple-carry adder; x + y + z with carry-out.
module ripple_adder (
    input  logic [8:0] x,
    input  logic [8:0] y,
    input  logic       z,
    output logic [8:0] s,
    output logic       cout
);

    logic [9:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = z;
        for (int i = 0; i < 9; i++) begin
            s[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout = c[9];

endmodule

// File: rtl/multiplier_control.sv
// Sequencer and A/B/X/M registers for the 8-bit signed shift-add multiplier.
// The last iteration subtracts M because the multiplier's MSB carries negative weight.
module multiplier_control
    import mult_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              ClearA_LoadB,
    input  logic [MULT_W-1:0] S,
    output logic [MULT_W-1:0] Aval,
    output logic [MULT_W-1:0] Bval,
    output logic              X,
    output logic              done
);

    state_t            state;
    state_t            state_next;
    logic [MULT_W-1:0] a_reg;
    logic [MULT_W-1:0] b_reg;
    logic [MULT_W-1:0] m_reg;
    logic              x_reg;
    cnt_t              cnt;

    logic              sub;
    logic [MULT_W:0]   add_x;
    logic [MULT_W:0]   add_y;
    logic              add_z;
    logic [MULT_W:0]   add_s;
    logic              adder_cout_unused;

    ripple_adder u_adder (
        .x    (add_x),
        .y    (add_y),
        .z    (add_z),
        .s    (add_s),
        .cout (adder_cout_unused)
    );

    always_comb begin
        state_next = state;
        sub        = (cnt == LAST_ITER);
        add_x      = {a_reg[MULT_W-1], a_reg};
        add_y      = {m_reg[MULT_W-1], m_reg} ^ {(MULT_W + 1){sub}};
        add_z      = sub;
        case (state)
            IDLE:    if (Run) state_next = CLR;
            CLR:     state_next = ADD;
            ADD:     state_next = SHIFT;
            SHIFT:   state_next = (cnt == LAST_ITER) ? HOLD : ADD;
            HOLD:    if (!Run) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // done is decoded from the next state so it is a clean register aligned with HOLD.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            m_reg <= '0;
            x_reg <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == HOLD);
            case (state)
                IDLE: begin
                    if (!Run && ClearA_LoadB) begin
                        a_reg <= '0;
                        x_reg <= 1'b0;
                        b_reg <= S;
                    end
                end
                CLR: begin
                    a_reg <= '0;
                    x_reg <= 1'b0;
                    m_reg <= S;
                    cnt   <= '0;
                end
                ADD: begin
                    if (b_reg[0]) {x_reg, a_reg} <= add_s;
                end
                SHIFT: begin
                    a_reg <= {x_reg, a_reg[MULT_W-1:1]};
                    b_reg <= {a_reg[0], b_reg[MULT_W-1:1]};
                    cnt   <= cnt + cnt_t'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign Aval = a_reg;
    assign Bval = b_reg;
    assign X    = x_reg;

endmodule
